// File: rtl/div_result_packer_if.sv
// Bus between the divider result port, the result packer and the UART TX byte port.
// Handshake: a byte transfers on a rising clk edge where tx_valid & tx_ready; tx_valid/tx_data hold until then.
interface div_result_packer_if #(
   parameter int N = 8
);
   logic         res_valid;
   logic [N-1:0] div_out;
   logic [N-1:0] remainder;
   logic         error;
   logic         res_ready;
   logic [7:0]   tx_data;
   logic         tx_valid;
   logic         tx_ready;

   modport master (
      output res_valid, div_out, remainder, error, tx_ready,
      input  res_ready, tx_data, tx_valid
   );

   modport slave (
      input  res_valid, div_out, remainder, error, tx_ready,
      output res_ready, tx_data, tx_valid
   );
endinterface

// File: rtl/div_result_packer.sv
// Buffers divider results in a small FIFO and serialises each one into a byte frame
// (header, then quotient and remainder MSB first; error results send the header only).
module div_result_packer #(
   parameter int         N       = 8,
   parameter int         DEPTH   = 2,
   parameter logic [7:0] HDR_OK  = 8'hA5,
   parameter logic [7:0] HDR_ERR = 8'hEE
) (
   input  logic                 clk,
   input  logic                 rst,
   div_result_packer_if.slave   bus,
   output logic                 busy,
   output logic [7:0]           ovf_cnt,
   output logic [1:0]           state_dbg
);
   localparam int NB = (N + 7) / 8;
   localparam int PW = NB * 8;
   localparam int W  = 2 * N + 1;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;

   typedef enum logic [1:0] {IDLE, HDR, QUO, REM} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   mem [DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  count;
   logic           full, empty, push, drop, pop;
   logic [W-1:0]   head;
   logic           hold_err;
   logic [PW-1:0]  hold_quo, hold_rem;
   logic [IW-1:0]  idx_q, idx_d;
   logic [7:0]     tx_data_q, tx_data_d;
   logic           tx_valid_q, tx_valid_d;
   logic           hs;

   function automatic logic [7:0] byte_sel(input logic [PW-1:0] v, input logic [IW-1:0] i);
      return v[i*8 +: 8];
   endfunction

   // Full is judged on the count before the edge, so a push while full drops even if a pop coincides.
   assign full          = (count == CW'(DEPTH));
   assign empty         = (count == '0);
   assign push          = bus.res_valid && !full;
   assign drop          = bus.res_valid && full;
   assign head          = mem[rd_ptr];
   assign hs            = tx_valid_q && bus.tx_ready;
   assign bus.res_ready = !full;
   assign bus.tx_data   = tx_data_q;
   assign bus.tx_valid  = tx_valid_q;
   assign busy          = (state_q != IDLE) || !empty;
   assign state_dbg     = state_q;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {bus.error, bus.div_out, bus.remainder};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ovf_cnt <= 8'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
         if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         tx_data_q  <= 8'd0;
         tx_valid_q <= 1'b0;
         idx_q      <= '0;
         hold_err   <= 1'b0;
         hold_quo   <= '0;
         hold_rem   <= '0;
      end else begin
         state_q    <= state_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         idx_q      <= idx_d;
         if (pop) begin
            hold_err <= head[W-1];
            hold_quo <= PW'(head[2*N-1:N]);
            hold_rem <= PW'(head[N-1:0]);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      idx_d      = idx_q;
      pop        = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               tx_valid_d = 1'b1;
               tx_data_d  = head[W-1] ? HDR_ERR : HDR_OK;
               state_d    = HDR;
            end
         end
         HDR: begin
            if (hs) begin
               if (hold_err) begin
                  tx_valid_d = 1'b0;
                  state_d    = IDLE;
               end else begin
                  idx_d     = IW'(NB - 1);
                  tx_data_d = byte_sel(hold_quo, IW'(NB - 1));
                  state_d   = QUO;
               end
            end
         end
         QUO: begin
            if (hs) begin
               if (idx_q == '0) begin
                  idx_d     = IW'(NB - 1);
                  tx_data_d = byte_sel(hold_rem, IW'(NB - 1));
                  state_d   = REM;
               end else begin
                  idx_d     = idx_q - IW'(1);
                  tx_data_d = byte_sel(hold_quo, idx_q - IW'(1));
               end
            end
         end
         REM: begin
            if (hs) begin
               if (idx_q == '0) begin
                  tx_valid_d = 1'b0;
                  state_d    = IDLE;
               end else begin
                  idx_d     = idx_q - IW'(1);
                  tx_data_d = byte_sel(hold_rem, idx_q - IW'(1));
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_div_result_packer.sv
// Bench for div_result_packer: queue-level model of FIFO and frame stream, plus directed literal checks.
module tb_div_result_packer;
   localparam int N     = 8;
   localparam int DEPTH = 2;
   localparam int NB    = (N + 7) / 8;

   logic       clk;
   logic       rst;
   logic       busy;
   logic [7:0] ovf_cnt;
   logic [1:0] state_dbg;

   div_result_packer_if #(.N(N)) bus ();

   div_result_packer #(.N(N), .DEPTH(DEPTH), .HDR_OK(8'hA5), .HDR_ERR(8'hEE)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .busy      (busy),
      .ovf_cnt   (ovf_cnt),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: FIFO of results, queue of bytes still to send for the current frame
   logic [2*N:0] m_fifo[$];
   logic [7:0]   exp_q[$];
   int           m_ovf   = 0;
   bit           model_on = 0;
   logic [7:0]   got_q[$];
   logic [7:0]   want_q[$];

   task automatic add_frame(input logic [2*N:0] e);
      logic [8*NB-1:0] q, r;
      if (e[2*N]) begin
         exp_q.push_back(8'hEE);
      end else begin
         q = (8*NB)'(e[2*N-1:N]);
         r = (8*NB)'(e[N-1:0]);
         exp_q.push_back(8'hA5);
         for (int i = NB - 1; i >= 0; i--) exp_q.push_back(q[8*i +: 8]);
         for (int i = NB - 1; i >= 0; i--) exp_q.push_back(r[8*i +: 8]);
      end
   endtask

   always @(posedge clk) begin
      int pre;
      if (rst) begin
         m_fifo.delete();
         exp_q.delete();
         m_ovf    = 0;
         model_on = 1;
      end else begin
         pre = m_fifo.size();
         if (exp_q.size() == 0) begin
            if (pre > 0) add_frame(m_fifo.pop_front());
         end else if (bus.tx_ready) begin
            void'(exp_q.pop_front());
         end
         if (bus.res_valid) begin
            if (pre < DEPTH) m_fifo.push_back({bus.error, bus.div_out, bus.remainder});
            else if (m_ovf < 255) m_ovf++;
         end
      end
   end

   // scoreboard compare, every cycle out of reset
   always @(negedge clk) begin
      if (model_on && !rst) begin
         check("tx_valid", 32'(bus.tx_valid), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) check("tx_data", 32'(bus.tx_data), 32'(exp_q[0]));
         check("res_ready", 32'(bus.res_ready), 32'(m_fifo.size() < DEPTH));
         check("busy", 32'(busy), 32'((exp_q.size() != 0) || (m_fifo.size() != 0)));
         check("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
         if (bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
      end
   end

   // driver tasks
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [N-1:0] q, input logic [N-1:0] r, input logic e);
      bus.res_valid = 1'b1;
      bus.div_out   = q;
      bus.remainder = r;
      bus.error     = e;
      cycle();
      bus.res_valid = 1'b0;
      bus.div_out   = '0;
      bus.remainder = '0;
      bus.error     = 1'b0;
   endtask

   task automatic wait_drain(input int max);
      int k = 0;
      while ((busy || bus.tx_valid) && k < max) begin
         cycle();
         k++;
      end
      check("drain_in_time", 32'(k < max), 32'd1);
   endtask

   task automatic check_frames(input string name);
      check({name, "_len"}, 32'(got_q.size()), 32'(want_q.size()));
      for (int i = 0; i < want_q.size() && i < got_q.size(); i++)
         check($sformatf("%s_byte%0d", name, i), 32'(got_q[i]), 32'(want_q[i]));
      got_q.delete();
      want_q.delete();
   endtask

   initial begin
      rst           = 1'b1;
      bus.res_valid = 1'b0;
      bus.div_out   = '0;
      bus.remainder = '0;
      bus.error     = 1'b0;
      bus.tx_ready  = 1'b0;
      cycle();
      cycle();
      check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      check("rst_tx_data", 32'(bus.tx_data), 32'h00);
      check("rst_ovf", 32'(ovf_cnt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_res_ready", 32'(bus.res_ready), 32'd1);
      check("rst_state", 32'(state_dbg), 32'd0);
      rst = 1'b0;

      // 12/5 -> A5 02 02, header one cycle after the push edge
      bus.tx_ready = 1'b1;
      push(8'd2, 8'd2, 1'b0);
      cycle();
      check("t1_hdr_valid", 32'(bus.tx_valid), 32'd1);
      check("t1_hdr_data", 32'(bus.tx_data), 32'hA5);
      wait_drain(20);
      want_q = '{8'hA5, 8'h02, 8'h02};
      check_frames("t1_frame");
      check("t1_busy_low", 32'(busy), 32'd0);

      // 11/0 -> EE only
      push(8'd0, 8'd0, 1'b1);
      wait_drain(20);
      want_q = '{8'hEE};
      check_frames("t2_frame");
      check("t2_ovf", 32'(ovf_cnt), 32'd0);

      // stall: 5/3, 15/14, 15/1 fill frame + FIFO, 7/7 dropped
      bus.tx_ready = 1'b0;
      push(8'd1, 8'd2, 1'b0);
      push(8'd1, 8'd1, 1'b0);
      push(8'd15, 8'd0, 1'b0);
      push(8'd1, 8'd0, 1'b0);
      check("t3_res_ready", 32'(bus.res_ready), 32'd0);
      check("t3_ovf", 32'(ovf_cnt), 32'd1);
      for (int k = 0; k < 4; k++) begin
         check("t3_stall_valid", 32'(bus.tx_valid), 32'd1);
         check("t3_stall_data", 32'(bus.tx_data), 32'hA5);
         cycle();
      end
      for (int k = 0; k < 200 && (busy || bus.tx_valid); k++) begin
         bus.tx_ready = 1'($urandom_range(0, 1));
         cycle();
      end
      bus.tx_ready = 1'b1;
      wait_drain(20);
      want_q = '{8'hA5, 8'h01, 8'h02, 8'hA5, 8'h01, 8'h01, 8'hA5, 8'h0F, 8'h00};
      check_frames("t3_frames");

      // reset during the quotient byte
      bus.tx_ready = 1'b0;
      push(8'd2, 8'd2, 1'b0);
      cycle();
      bus.tx_ready = 1'b1;
      cycle();
      bus.tx_ready = 1'b0;
      check("t4_in_quo", 32'(state_dbg), 32'd2);
      check("t4_quo_data", 32'(bus.tx_data), 32'h02);
      rst = 1'b1;
      cycle();
      check("t4_tx_valid", 32'(bus.tx_valid), 32'd0);
      check("t4_busy", 32'(busy), 32'd0);
      check("t4_res_ready", 32'(bus.res_ready), 32'd1);
      check("t4_ovf", 32'(ovf_cnt), 32'd0);
      rst = 1'b0;
      got_q.delete();
      bus.tx_ready = 1'b1;
      push(8'd1, 8'd0, 1'b0);
      wait_drain(20);
      want_q = '{8'hA5, 8'h01, 8'h00};
      check_frames("t4_frame");

      // push while full on the same edge as a pop
      bus.tx_ready = 1'b0;
      push(8'd2, 8'd2, 1'b0);
      push(8'd2, 8'd1, 1'b0);
      push(8'd0, 8'd0, 1'b1);
      check("t5_full", 32'(bus.res_ready), 32'd0);
      bus.tx_ready = 1'b1;
      cycle();
      cycle();
      cycle();
      push(8'd3, 8'd0, 1'b0);
      check("t5_ovf", 32'(ovf_cnt), 32'd1);
      check("t5_res_ready", 32'(bus.res_ready), 32'd1);
      check("t5_popped_hdr", 32'(bus.tx_data), 32'hA5);
      wait_drain(30);
      want_q = '{8'hA5, 8'h02, 8'h02, 8'hA5, 8'h02, 8'h01, 8'hEE};
      check_frames("t5_frames");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
